// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter: FSM state encodings,
// arbitration mode values and default block address/data widths.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_RD      = 2'd1,
        ARB_WR      = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 128;

    // A single channel still needs a 1-bit pointer/index signal.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational winner selection: one-hot grant plus binary index, either the
// lowest requesting channel or the first one at or after rr_ptr (wrapping).
module mem_port_arbiter_rr_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ARB_MODE = ARB_RR,
    localparam int PTR_W   = ptr_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  rr_ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [PTR_W-1:0]  grant_idx,
    output logic              any_req
);

    int               start_idx;
    int               idx;
    logic [PTR_W-1:0] sel;
    logic             found;

    assign any_req = |req;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        sel       = '0;
        start_idx = (ARB_MODE == ARB_RR) ? int'(rr_ptr) : 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = start_idx + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            sel = PTR_W'(idx);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one block-wide memory port among NUM_CH cache controllers, granting one
// whole read or write transaction at a time with fully registered outputs.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_ren,
    input  logic [NUM_CH-1:0]        ch_wen,
    input  logic [NUM_CH*ADDR_W-1:0] ch_block_address,
    input  logic [NUM_CH*DATA_W-1:0] ch_din,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [DATA_W-1:0]        ch_dout,
    output logic [NUM_CH-1:0]        ch_grant,
    output logic                     mem_ren,
    output logic                     mem_wen,
    output logic [ADDR_W-1:0]        mem_block_address,
    output logic [DATA_W-1:0]        mem_din,
    input  logic                     mem_ready,
    input  logic                     mem_done,
    input  logic [DATA_W-1:0]        mem_dout
);

    localparam int PTR_W = ptr_width(NUM_CH);

    arb_state_t       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] pick_idx;
    logic [NUM_CH-1:0] pick;
    logic             any_req;
    logic [ADDR_W-1:0] addr_arr [NUM_CH];
    logic [DATA_W-1:0] din_arr  [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign addr_arr[i] = ch_block_address[i*ADDR_W +: ADDR_W];
        assign din_arr[i]  = ch_din[i*DATA_W +: DATA_W];
    end

    mem_port_arbiter_rr_pick #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_pick (
        .req       (ch_ren | ch_wen),
        .rr_ptr    (rr_ptr),
        .grant     (pick),
        .grant_idx (pick_idx),
        .any_req   (any_req)
    );

    // Pulses default low every cycle; the owner index is latched at grant so
    // later changes on the request lines cannot redirect a pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= ARB_IDLE;
            rr_ptr            <= '0;
            owner             <= '0;
            ch_ready          <= '0;
            ch_done           <= '0;
            ch_dout           <= '0;
            ch_grant          <= '0;
            mem_ren           <= 1'b0;
            mem_wen           <= 1'b0;
            mem_block_address <= '0;
            mem_din           <= '0;
        end else begin
            ch_ready <= '0;
            ch_done  <= '0;
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        owner             <= pick_idx;
                        ch_grant          <= pick;
                        mem_block_address <= addr_arr[pick_idx];
                        mem_din           <= din_arr[pick_idx];
                        // A held write goes first so a dirty writeback precedes its fill.
                        if (ch_wen[pick_idx]) begin
                            mem_wen <= 1'b1;
                            state   <= ARB_WR;
                        end else begin
                            mem_ren <= 1'b1;
                            state   <= ARB_RD;
                        end
                    end
                end
                ARB_RD: begin
                    if (mem_ready) begin
                        ch_dout         <= mem_dout;
                        ch_ready[owner] <= 1'b1;
                        mem_ren         <= 1'b0;
                        state           <= ARB_RELEASE;
                    end
                end
                ARB_WR: begin
                    if (mem_done) begin
                        ch_done[owner] <= 1'b1;
                        mem_wen        <= 1'b0;
                        state          <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    ch_grant <= '0;
                    rr_ptr   <= (owner == PTR_W'(NUM_CH - 1)) ? '0 : owner + PTR_W'(1);
                    state    <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
